lsu_mem_op_sequencer: RTL
=========================

LSU_MEM_OP_SEQUENCER -- requirements
Module: lsu_mem_op_sequencer

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous and active-high.
REQ-003 issue_valid  in  1  decoded LSU op present.
REQ-004 issue_ready  out  1  sequencer can accept an op.
REQ-005 issue_op_rd / issue_op_wr  in  1 each  read / write op from the decoder.
REQ-006 issue_op_cnt  in  6  lanes minus one per depth slice (0..63).
REQ-007 issue_gpr_op_depth  in  2  depth slices minus one (0..3).
REQ-008 issue_mem_gpr  in  1  0 = SGPR target, 1 = VGPR target.
REQ-009 issue_base_addr  in  32  byte base address.
REQ-010 mem_rd_en / mem_wr_en  out  1 each  memory request strobes.
REQ-011 mem_addr  out  32  request byte address.
REQ-012 mem_ack  in  1  memory completion.
REQ-013 mem_rd_data  in  32  read data, valid with mem_ack.
REQ-014 gpr_wr_en  out  1  GPR writeback strobe.
REQ-015 gpr_wr_data  out  32  writeback data.
REQ-016 gpr_lane_idx  out  6  current lane index.
REQ-017 gpr_depth_idx  out  2  current depth slice.
REQ-018 gpr_sel  out  1  latched issue_mem_gpr.
REQ-019 op_done  out  1  one-cycle completion pulse.

Function
REQ-020 States: IDLE, REQ, WAIT_ACK, DONE; issue_ready SHALL be 1 only in IDLE.
REQ-021 In IDLE, issue_valid=1 SHALL latch all issue_* inputs and clear the lane, depth and beat counters; next state is REQ if rd or wr, else DONE.
REQ-022 If issue_op_rd and issue_op_wr are both 1, read SHALL take priority and write SHALL be ignored.
REQ-023 In REQ, exactly one of mem_rd_en/mem_wr_en SHALL be 1 for exactly one cycle; next state is WAIT_ACK.
REQ-024 mem_addr SHALL equal base + 4*beat, where beat = depth_idx*(op_cnt+1) + lane_idx, computed modulo 2^32 (wraps, no error).
REQ-025 mem_ack SHALL be sampled only in WAIT_ACK; mem_ack in any other state SHALL be ignored.
REQ-026 For a read, gpr_wr_en SHALL equal 1 in the same cycle as mem_ack in WAIT_ACK, with gpr_wr_data = mem_rd_data; for a write, gpr_wr_en SHALL stay 0.
REQ-027 On ack: if lane_idx < op_cnt, lane_idx increments and the next state is REQ; else lane_idx returns to 0 and depth_idx increments (next state REQ) unless depth_idx = depth, in which case the next state is DONE.
REQ-028 Beat order SHALL be lane-inner, depth-outer; total beats = (op_cnt+1)*(depth+1), at most 256.
REQ-029 DONE SHALL assert op_done for one cycle, then return to IDLE; back-to-back ops SHALL therefore be separated by at least one IDLE cycle.
REQ-030 gpr_lane_idx, gpr_depth_idx and gpr_sel SHALL be held stable from REQ through the matching ack.
REQ-031 Issue inputs SHALL be ignored outside IDLE.
REQ-032 The sequencer SHALL wait indefinitely for mem_ack (no timeout).

Reset
REQ-033 rst=1 SHALL force IDLE on the next edge in any state, including mid-operation, discarding the in-flight op and any later mem_ack for it.
REQ-034 Reset values: issue_ready=1 after the reset edge; mem_rd_en, mem_wr_en, gpr_wr_en and op_done = 0; mem_addr, gpr_wr_data, gpr_lane_idx and gpr_depth_idx = 0; gpr_sel = 0.
REQ-035 rst SHALL take priority over issue_valid in the same cycle.

Verification
REQ-036 s_load_dwordx2 style: rd=1, cnt=1, depth=0, base=0x100, ack 2 cycles after each request -> mem_addr 0x100 then 0x104, two gpr_wr_en with lane 0 and 1, then op_done.
REQ-037 tbuffer_store_xyzw style: wr=1, cnt=63, depth=3, base=0 -> 256 mem_wr_en strobes, addresses 0x000..0x3FC, gpr_wr_en never set, depth_idx steps 0..3, single op_done.
REQ-038 rd=0, wr=0, issue_valid=1 -> no memory strobe; op_done 2 cycles after issue; issue_ready back to 1.
REQ-039 base=0xFFFFFFFC, rd=1, cnt=1 -> addresses 0xFFFFFFFC then 0x00000000.
REQ-040 rst pulsed in WAIT_ACK of beat 3 of 8, with mem_ack the cycle after -> IDLE, no gpr_wr_en, no op_done; a new op then runs normally.
REQ-041 mem_ack held high in IDLE and REQ -> no state change until WAIT_ACK; the REQ strobe lasts exactly one cycle.

Source files
------------

// File: rtl/lsu_mem_op_sequencer.sv
// -----------------------------------------------------------------------------
// lsu_mem_op_sequencer
//
// Turns one decoded LSU memory op into a series of single-word memory
// requests. An op covers (op_cnt+1) lanes in each of (depth+1) depth slices.
// Beats are walked lane-inner, depth-outer. Each beat issues one read or write
// strobe, then waits as long as needed for mem_ack. For reads, the returned
// word is forwarded to the GPR file in the same cycle the ack arrives.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   issue_valid/ready    op handshake (ready only while idle)
//   issue_op_rd/wr       read / write op (read wins if both are set)
//   issue_op_cnt         lanes minus one per depth slice
//   issue_gpr_op_depth   depth slices minus one
//   issue_mem_gpr        0 = SGPR target, 1 = VGPR target
//   issue_base_addr      byte base address of the op
//   mem_rd_en/wr_en      one-cycle request strobes
//   mem_addr             request byte address (base + 4*beat, wraps)
//   mem_ack, mem_rd_data memory completion and read data
//   gpr_wr_en/wr_data    read writeback, combinational with mem_ack
//   gpr_lane_idx         current lane
//   gpr_depth_idx        current depth slice
//   gpr_sel              latched GPR target select
//   op_done              one-cycle completion pulse
// -----------------------------------------------------------------------------
module lsu_mem_op_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        issue_op_rd,
  input  logic        issue_op_wr,
  input  logic [5:0]  issue_op_cnt,
  input  logic [1:0]  issue_gpr_op_depth,
  input  logic        issue_mem_gpr,
  input  logic [31:0] issue_base_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rd_data,
  output logic        gpr_wr_en,
  output logic [31:0] gpr_wr_data,
  output logic [5:0]  gpr_lane_idx,
  output logic [1:0]  gpr_depth_idx,
  output logic        gpr_sel,
  output logic        op_done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      state;
  logic        op_is_rd;
  logic [5:0]  op_cnt_q;
  logic [1:0]  depth_q;
  logic [31:0] base_q;
  logic [7:0]  beat_q;

  logic        ack_seen;
  logic        last_lane;
  logic        last_depth;
  logic [7:0]  beat_next;
  logic [31:0] next_addr;

  // An ack only counts while waiting for one. Gating with rst keeps an ack
  // that lands in the reset cycle from reaching the GPR file.
  assign ack_seen   = (state == WAIT_ACK) && mem_ack && !rst;
  assign last_lane  = (gpr_lane_idx == op_cnt_q);
  assign last_depth = (gpr_depth_idx == depth_q);
  assign beat_next  = beat_q + 8'd1;
  // beat_next stays below 256, so the shifted beat fits in 10 bits. The
  // 32-bit add wraps past the top of the address space without error.
  assign next_addr  = base_q + {22'd0, beat_next, 2'b00};

  // Read writeback must appear in the same cycle as the ack, so it is not
  // registered. The data bus reads as zero whenever no write is in progress.
  assign gpr_wr_en   = ack_seen && op_is_rd;
  assign gpr_wr_data = gpr_wr_en ? mem_rd_data : 32'd0;

  // Single state machine. Every visible output except the writeback pair is
  // a register, assigned with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      issue_ready   <= 1'b1;
      mem_rd_en     <= 1'b0;
      mem_wr_en     <= 1'b0;
      mem_addr      <= 32'd0;
      gpr_lane_idx  <= 6'd0;
      gpr_depth_idx <= 2'd0;
      gpr_sel       <= 1'b0;
      op_done       <= 1'b0;
      op_is_rd      <= 1'b0;
      op_cnt_q      <= 6'd0;
      depth_q       <= 2'd0;
      base_q        <= 32'd0;
      beat_q        <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_valid) begin
            op_is_rd      <= issue_op_rd;
            op_cnt_q      <= issue_op_cnt;
            depth_q       <= issue_gpr_op_depth;
            base_q        <= issue_base_addr;
            gpr_sel       <= issue_mem_gpr;
            gpr_lane_idx  <= 6'd0;
            gpr_depth_idx <= 2'd0;
            beat_q        <= 8'd0;
            issue_ready   <= 1'b0;
            if (issue_op_rd || issue_op_wr) begin
              state     <= REQ;
              mem_rd_en <= issue_op_rd;
              mem_wr_en <= !issue_op_rd;
              mem_addr  <= issue_base_addr;
            end else begin
              // An op with neither direction does no memory traffic.
              state   <= DONE;
              op_done <= 1'b1;
            end
          end
        end

        REQ: begin
          mem_rd_en <= 1'b0;
          mem_wr_en <= 1'b0;
          state     <= WAIT_ACK;
        end

        WAIT_ACK: begin
          if (ack_seen) begin
            beat_q <= beat_next;
            if (!last_lane || !last_depth) begin
              if (!last_lane) begin
                gpr_lane_idx <= gpr_lane_idx + 6'd1;
              end else begin
                gpr_lane_idx  <= 6'd0;
                gpr_depth_idx <= gpr_depth_idx + 2'd1;
              end
              state     <= REQ;
              mem_rd_en <= op_is_rd;
              mem_wr_en <= !op_is_rd;
              mem_addr  <= next_addr;
            end else begin
              gpr_lane_idx <= 6'd0;
              state        <= DONE;
              op_done      <= 1'b1;
            end
          end
        end

        DONE: begin
          op_done     <= 1'b0;
          issue_ready <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          state       <= IDLE;
          issue_ready <= 1'b1;
          mem_rd_en   <= 1'b0;
          mem_wr_en   <= 1'b0;
          op_done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
